// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants for the RISC-V pipeline: forwarding selects and the zero register index
package riscv_pkg;

  // Encodings for the EX-stage 3:1 operand mux select
  localparam logic [1:0] FWD_REG   = 2'b00;  // register-file read data
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // result held in EX/MEM
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // result held in MEM/WB

  // x0 is hardwired to zero, so it never takes part in forwarding or hazards
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_sel_predict.sv
// rtl/fwd_sel_predict.sv - combinational forwarding-select prediction for one source operand
// Ports:
//   rs, rs_used                 source register index and whether the instruction reads it
//   ex_rd, ex_reg_write, ex_valid  instruction now in EX, which is in EX/MEM one cycle later
//   mem_rd, mem_reg_write       instruction now in EX/MEM, which is in MEM/WB one cycle later
//   sel                         select to be registered alongside the operand
module fwd_sel_predict
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic                      rs_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_reg_write,
  output logic [1:0]                sel
);

  localparam logic [REG_ADDR_WIDTH-1:0] RS_ZERO = REG_ADDR_WIDTH'(REG_ZERO);

  // The younger producer (the one now in EX) is checked first so that it
  // overrides an older write to the same register.
  always_comb begin
    sel = FWD_REG;
    if (rs_used && (rs != RS_ZERO)) begin
      if (ex_valid && ex_reg_write && (ex_rd == rs)) begin
        sel = FWD_EXMEM;
      end else if (mem_reg_write && (mem_rd == rs)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and registered forwarding selects
// Ports:
//   id_*                decoded instruction from the decode stage
//   mem_rd, mem_reg_write  destination of the instruction in EX/MEM
//   flush, ex_hold      squash from a resolved branch / downstream freeze
//   id_stall            combinational: hold PC and IF/ID on this edge
//   ex_*                registered operands, control and operand-mux selects
// Optional build macro HAZARD_STATS_EN adds saturating stall_count / flush_count outputs.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic                      mem_reg_write,
  input  logic                      flush,
  input  logic                      ex_hold,
  output logic                      id_stall,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic                      ex_mem_read,
  output logic [DATA_WIDTH-1:0]     ex_rs1_data,
  output logic [DATA_WIDTH-1:0]     ex_rs2_data,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
`ifdef HAZARD_STATS_EN
  output logic [31:0]               stall_count,
  output logic [31:0]               flush_count,
`endif
  output logic [1:0]                ex_fwd_a,
  output logic [1:0]                ex_fwd_b
);

  localparam logic [REG_ADDR_WIDTH-1:0] RD_ZERO = REG_ADDR_WIDTH'(REG_ZERO);

  logic       load_use;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  // A load in EX cannot forward until it reaches MEM/WB, so a dependent
  // instruction in decode has to wait one cycle.
  assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd != RD_ZERO) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  // Flush kills the decode instruction, so stalling it would be pointless.
  // Gating with rst_n keeps id_stall low while held in reset even if ex_hold is up.
  assign id_stall = rst_n && !flush && (ex_hold || load_use);

  fwd_sel_predict #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs            (id_rs1),
    .rs_used       (id_rs1_used),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_valid      (ex_valid),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .sel           (sel_a)
  );

  fwd_sel_predict #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs            (id_rs2),
    .rs_used       (id_rs2_used),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_valid      (ex_valid),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .sel           (sel_b)
  );

  // Bubbles clear only control and selects; data fields keep their old
  // values since nothing downstream looks at them when ex_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_rs1_data  <= '0;
      ex_rs2_data  <= '0;
      ex_pc        <= '0;
      ex_rd        <= '0;
      ex_fwd_a     <= FWD_REG;
      ex_fwd_b     <= FWD_REG;
    end else if (flush || (!ex_hold && load_use)) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_fwd_a     <= FWD_REG;
      ex_fwd_b     <= FWD_REG;
    end else if (!ex_hold) begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_valid && id_reg_write;
      ex_mem_read  <= id_valid && id_mem_read;
      ex_rs1_data  <= id_rs1_data;
      ex_rs2_data  <= id_rs2_data;
      ex_pc        <= id_pc;
      ex_rd        <= id_rd;
      ex_fwd_a     <= id_valid ? sel_a : FWD_REG;
      ex_fwd_b     <= id_valid ? sel_b : FWD_REG;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (flush) begin
        if (flush_count != '1) flush_count <= flush_count + 32'd1;
      end else if (!ex_hold && load_use) begin
        if (stall_count != '1) stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule
